// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the in-order CPU operand/hazard control:
//   - RV32 opcode constants consumed by the ID-stage decoder
//   - operand-B select encoding (selb_e) and forwarding select encoding (fwd_e)
//   - state encoding for the load-use stall FSM
//   - decode_op(): opcode -> operand selects and source-usage flags
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        SELB_RS2  = 2'b00,
        SELB_IMM  = 2'b01,
        SELB_FOUR = 2'b10
    } selb_e;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_e;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_LU_STALL = 1'b1
    } ctrl_state_e;

    typedef struct packed {
        logic  sel_a;     // 1 = PC, 0 = rs1
        selb_e sel_b;
        logic  rs1_used;
        logic  rs2_used;
    } dec_t;

    function automatic dec_t decode_op(input logic [6:0] opc);
        dec_t d;
        d.sel_a    = (opc == OPC_JAL) || (opc == OPC_JALR) || (opc == OPC_AUIPC);
        case (opc)
            OPC_JAL, OPC_JALR: d.sel_b = SELB_FOUR;   // link address = PC + 4
            OPC_OP, OPC_BRANCH: d.sel_b = SELB_RS2;
            default:            d.sel_b = SELB_IMM;
        endcase
        d.rs1_used = !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
        d.rs2_used = (opc == OPC_OP) || (opc == OPC_BRANCH) || (opc == OPC_STORE);
        return d;
    endfunction

endpackage

// File: rtl/hazard_cmp.sv
// ---------------------------------------------------------------------------
// hazard_cmp
// Compares one ID source register against one downstream destination.
// Ports:
//   src_i   [4:0] source register index in ID
//   used_i        instruction actually reads this source
//   dst_i   [4:0] destination register of the downstream instruction
//   wr_i          downstream instruction writes dst_i
//   match_o       dependency exists (never for x0 or an unused source)
// ---------------------------------------------------------------------------
module hazard_cmp (
    input  logic [4:0] src_i,
    input  logic       used_i,
    input  logic [4:0] dst_i,
    input  logic       wr_i,
    output logic       match_o
);

    assign match_o = used_i && wr_i && (src_i != 5'd0) && (src_i == dst_i);

endmodule

// File: rtl/alu_operand_ctrl.sv
// ---------------------------------------------------------------------------
// alu_operand_ctrl
// ID-stage operand selection, forwarding and hazard control. Decodes the ID
// opcode into EX operand selects, resolves data dependencies on the EX and
// MEM instructions and registers the result into the EX stage (1 cycle).
//
// Configuration macro: ALU_OPERAND_CTRL_FWD_EN
//   defined   : full forwarding; only load-use stalls (one cycle, RUN/LU_STALL FSM)
//   undefined : no forwarding (fwd selects tied 00); any RAW dependency on the
//               EX or MEM destination stalls, capped at 2 cycles by a counter
//
// Ports:
//   clk, rst_n (sync, active-low)
//   id_valid, id_opcode[6:0], id_rs1[4:0], id_rs2[4:0]  ID instruction
//   ex_rd[4:0], ex_regwrite, ex_memread                 EX instruction dest
//   mem_rd[4:0], mem_regwrite                           MEM instruction dest
//   ex_branch_taken                                     flush request
//   id_stall                                            hold PC / IF-ID (comb)
//   ex_valid, ex_sel_a, ex_sel_b[1:0]                   registered EX selects
//   ex_fwd_a[1:0], ex_fwd_b[1:0]                        registered fwd selects
// ---------------------------------------------------------------------------
module alu_operand_ctrl
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid,
    input  logic [6:0] id_opcode,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_regwrite,
    input  logic       ex_memread,
    input  logic [4:0] mem_rd,
    input  logic       mem_regwrite,
    input  logic       ex_branch_taken,
    output logic       id_stall,
    output logic       ex_valid,
    output logic       ex_sel_a,
    output logic [1:0] ex_sel_b,
    output logic [1:0] ex_fwd_a,
    output logic [1:0] ex_fwd_b
);

    dec_t dec;
    assign dec = decode_op(id_opcode);

    // EX comparators see a raw index match; the write qualifier differs between
    // forwarding (ex_regwrite) and load-use detection (ex_memread).
    logic ex_raw_a, ex_raw_b, mem_hit_a, mem_hit_b;

    hazard_cmp u_cmp_a_ex  (.src_i(id_rs1), .used_i(dec.rs1_used), .dst_i(ex_rd),
                            .wr_i(1'b1), .match_o(ex_raw_a));
    hazard_cmp u_cmp_a_mem (.src_i(id_rs1), .used_i(dec.rs1_used), .dst_i(mem_rd),
                            .wr_i(mem_regwrite), .match_o(mem_hit_a));
    hazard_cmp u_cmp_b_ex  (.src_i(id_rs2), .used_i(dec.rs2_used), .dst_i(ex_rd),
                            .wr_i(1'b1), .match_o(ex_raw_b));
    hazard_cmp u_cmp_b_mem (.src_i(id_rs2), .used_i(dec.rs2_used), .dst_i(mem_rd),
                            .wr_i(mem_regwrite), .match_o(mem_hit_b));

    logic       stall_c;
    logic [1:0] fwd_a_c, fwd_b_c;

`ifdef ALU_OPERAND_CTRL_FWD_EN
    ctrl_state_e state_q, state_d;
    logic        load_use;

    assign load_use = id_valid && ex_memread && (ex_raw_a || ex_raw_b);

    always_comb begin
        stall_c = 1'b0;
        state_d = ST_RUN;
        if (!ex_branch_taken && (state_q == ST_RUN) && load_use) begin
            stall_c = 1'b1;
            state_d = ST_LU_STALL;
        end
    end

    // EX match wins over MEM match: it is the younger producer.
    always_comb begin
        fwd_a_c = FWD_RF;
        if (ex_raw_a && ex_regwrite) fwd_a_c = FWD_EXMEM;
        else if (mem_hit_a)          fwd_a_c = FWD_MEMWB;
        fwd_b_c = FWD_RF;
        if (ex_raw_b && ex_regwrite) fwd_b_c = FWD_EXMEM;
        else if (mem_hit_b)          fwd_b_c = FWD_MEMWB;
    end
`else
    logic [1:0] cnt_q, cnt_d;
    logic       ex_wr, raw_hazard;

    // A load writes its rd even if the core drives regwrite separately.
    assign ex_wr      = ex_regwrite || ex_memread;
    assign raw_hazard = id_valid && ((ex_raw_a && ex_wr) || (ex_raw_b && ex_wr) ||
                                     mem_hit_a || mem_hit_b);

    // The counter caps a dependency stall at two cycles: by then the producer
    // has drained past MEM and the register file holds the value.
    always_comb begin
        stall_c = !ex_branch_taken && raw_hazard && (cnt_q != 2'd2);
        cnt_d   = stall_c ? cnt_q + 2'd1 : 2'd0;
        fwd_a_c = FWD_RF;
        fwd_b_c = FWD_RF;
    end
`endif

    assign id_stall = rst_n && stall_c;

    logic       ex_valid_q, ex_sel_a_q;
    logic [1:0] ex_sel_b_q, ex_fwd_a_q, ex_fwd_b_q;

    // ID -> EX register: bubble on stall or flush, else the decoded instruction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
`ifdef ALU_OPERAND_CTRL_FWD_EN
            state_q <= ST_RUN;
`else
            cnt_q   <= 2'd0;
`endif
            ex_valid_q <= 1'b0;
            ex_sel_a_q <= 1'b0;
            ex_sel_b_q <= 2'b00;
            ex_fwd_a_q <= 2'b00;
            ex_fwd_b_q <= 2'b00;
        end else begin
`ifdef ALU_OPERAND_CTRL_FWD_EN
            state_q <= state_d;
`else
            cnt_q   <= cnt_d;
`endif
            if (ex_branch_taken || stall_c) begin
                ex_valid_q <= 1'b0;
                ex_sel_a_q <= 1'b0;
                ex_sel_b_q <= 2'b00;
                ex_fwd_a_q <= 2'b00;
                ex_fwd_b_q <= 2'b00;
            end else begin
                ex_valid_q <= id_valid;
                ex_sel_a_q <= dec.sel_a;
                ex_sel_b_q <= dec.sel_b;
                ex_fwd_a_q <= fwd_a_c;
                ex_fwd_b_q <= fwd_b_c;
            end
        end
    end

    assign ex_valid = ex_valid_q;
    assign ex_sel_a = ex_sel_a_q;
    assign ex_sel_b = ex_sel_b_q;
    assign ex_fwd_a = ex_fwd_a_q;
    assign ex_fwd_b = ex_fwd_b_q;

endmodule

// File: doc/alu_operand_ctrl.md
ALU_OPERAND_CTRL -- requirements
Module: alu_operand_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock, sole clock domain.
REQ-002 SHALL have: rst_n  in  1  synchronous, active-low reset, sampled on clk rising edge.
REQ-003 SHALL have: id_valid  in  1  ID stage holds a valid instruction.
REQ-004 SHALL have: id_opcode  in  7, id_rs1  in  5, id_rs2  in  5  instruction fields of the ID instruction.
REQ-005 SHALL have: ex_rd  in  5, ex_regwrite  in  1, ex_memread  in  1  destination info of the instruction now in EX.
REQ-006 SHALL have: mem_rd  in  5, mem_regwrite  in  1  destination info of the instruction now in MEM.
REQ-007 SHALL have: ex_branch_taken  in  1  taken branch or jump resolved in EX; flush request.
REQ-008 SHALL have: id_stall  out  1  hold PC and IF/ID register this cycle (combinational).
REQ-009 SHALL have: ex_valid  out  1, ex_sel_a  out  1 (1=PC, 0=rs1), ex_sel_b  out  2 (00 rs2, 01 imm, 10 const 4)  registered EX operand selects.
REQ-010 SHALL have: ex_fwd_a  out  2, ex_fwd_b  out  2 (00 regfile, 01 EX/MEM, 10 MEM/WB)  registered forwarding selects.

Function
REQ-011 SHALL set ex_sel_a=1 for JAL(1101111), JALR(1100111), AUIPC(0010111); 0 otherwise.
REQ-012 SHALL set ex_sel_b=10 for JAL/JALR, 00 for OP(0110011) and BRANCH(1100011), 01 for all others.
REQ-013 SHALL treat rs1 as used except for LUI(0110111), AUIPC, JAL; rs2 used only for OP, BRANCH, STORE(0100011).
REQ-014 SHALL never flag a hazard or forward for source register x0 or for unused sources.
REQ-015 SHALL compute forward select per used source: match ex_rd with ex_regwrite -> 01; else match mem_rd with mem_regwrite -> 10; else 00; EX match has priority.
REQ-016 SHALL detect load-use when id_valid, ex_memread, ex_rd!=0 and ex_rd matches a used source.
REQ-017 SHALL implement FSM states RUN and LU_STALL: RUN -> LU_STALL on load-use; LU_STALL -> RUN unconditionally after one cycle.
REQ-018 SHALL, in RUN with load-use, assert id_stall and register a bubble (ex_valid=0, all selects 0).
REQ-019 SHALL, in LU_STALL, deassert id_stall and register the held instruction with re-evaluated forwarding (load now in MEM, select 10).
REQ-020 SHALL give ex_branch_taken priority: id_stall=0, next ex_valid=0, selects 0, FSM -> RUN, regardless of state.
REQ-021 SHALL register ex_valid=id_valid with decoded selects when neither stall nor flush applies; latency ID->EX outputs exactly one cycle.

Reset
REQ-022 SHALL, while rst_n=0 at a clk edge, force FSM=RUN, ex_valid=0, ex_sel_a=0, ex_sel_b=00, ex_fwd_a=ex_fwd_b=00; id_stall=0 during reset.
REQ-023 SHALL abandon an in-progress LU_STALL on reset with no residual bubble after release.

Configuration
REQ-024 SHALL honour macro ALU_OPERAND_CTRL_FWD_EN: defined -> behaviour per REQ-015..019.
REQ-025 SHALL, without ALU_OPERAND_CTRL_FWD_EN, tie ex_fwd_a/ex_fwd_b to 00 and stall (id_stall=1, bubble) while any used source matches a writing ex_rd or mem_rd, via a 2-bit stall counter state (max 2 cycles); flush still overrides.

Structure
REQ-026 SHALL take opcode constants, sel_b encodings and fwd encodings from shared package cpu_pkg.
REQ-027 SHALL instantiate sub-module hazard_cmp (source reg, used flag, dest reg, write flag -> match) once per source/destination pair.

Verification
REQ-028 SHALL cover: ADD x3,x1,x2 in ID with ex_rd=1,ex_regwrite=1 -> next cycle ex_fwd_a=01, ex_fwd_b=00, ex_sel_b=00.
REQ-029 SHALL cover: LW x5 in EX (ex_memread=1), ADDI x6,x5,1 in ID -> id_stall=1 one cycle, ex_valid=0, then ex_valid=1, ex_fwd_a=10.
REQ-030 SHALL cover: JAL in ID -> ex_sel_a=1, ex_sel_b=10, ex_fwd_a=00 even with ex_rd matching id_rs1.
REQ-031 SHALL cover: load-use and ex_branch_taken same cycle -> id_stall=0, ex_valid=0, FSM=RUN.
REQ-032 SHALL cover: source x0 with ex_rd=0, ex_regwrite=1 -> fwd 00, no stall; rst_n=0 during LU_STALL -> all outputs reset values next edge.
REQ-033 SHALL cover without FWD_EN: ADD x3,x1,x2 with ex_rd=1 -> id_stall=1 for 2 cycles, fwd outputs 00 throughout.
